// File: rtl/ws2812_frame_tx_if.sv
// Pixel-fetch port, frame control and WS2812 line signals between the
// register-file side and the serial encoder.
interface ws2812_frame_tx_if #(
    parameter int unsigned NUM_LEDS = 12
);
    localparam int unsigned ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic              start;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data;
    logic              dout;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output start,
        output pix_data,
        input  pix_addr,
        input  dout,
        input  busy,
        input  done,
        input  overrun
    );

    modport slave (
        input  start,
        input  pix_data,
        output pix_addr,
        output dout,
        output busy,
        output done,
        output overrun
    );
endinterface

// File: rtl/ws2812_frame_tx.sv
// WS2812 frame encoder: fetches NUM_LEDS RGB words, reorders them to GRB and
// drives the NRZ single-wire waveform MSB first, followed by the latch interval.
module ws2812_frame_tx #(
    parameter int unsigned NUM_LEDS   = 12,
    parameter int unsigned T0H_CYC    = 40,
    parameter int unsigned T1H_CYC    = 80,
    parameter int unsigned TBIT_CYC   = 125,
    parameter int unsigned TLATCH_CYC = 5000
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    ws2812_frame_tx_if.slave     bus
);

    localparam int unsigned LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned CYC_MAX = (TBIT_CYC > TLATCH_CYC) ? TBIT_CYC : TLATCH_CYC;
    localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        BIT   = 2'd2,
        LATCH = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [4:0]         bit_q, bit_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [LED_W-1:0]   addr_q, addr_d;
    logic [23:0]        shift_q, shift_d;
    logic [23:0]        hold_q, hold_d;
    logic               dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;

    // Register-file words are {R,G,B}; the wire order is {G,R,B}.
    function automatic logic [23:0] to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            led_q     <= '0;
            addr_q    <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            led_q     <= led_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic; registered outputs are derived from the next-state values
    // so dout/busy/done line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        led_d     = led_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        hold_d    = hold_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shift_d = to_grb(bus.pix_data);
                cyc_d   = '0;
                bit_d   = '0;
                led_d   = '0;
                state_d = BIT;
            end
            BIT: begin
                // Prefetched word arrives one cycle after the address moved.
                if (bit_q == 5'd0 && cyc_q == CYC_W'(1)) begin
                    hold_d = to_grb(bus.pix_data);
                end
                if (cyc_q == CYC_W'(TBIT_CYC - 1)) begin
                    cyc_d = '0;
                    if (bit_q == 5'd23) begin
                        bit_d = '0;
                        if (led_q < LED_W'(NUM_LEDS - 1)) begin
                            shift_d = hold_q;
                            led_d   = led_q + LED_W'(1);
                        end else begin
                            state_d = LATCH;
                        end
                    end else begin
                        shift_d = {shift_q[22:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            LATCH: begin
                if (cyc_q == CYC_W'(TLATCH_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Point the register file at the next pixel as each pixel begins.
        if (state_d == BIT && bit_d == 5'd0 && cyc_d == '0 &&
            led_d < LED_W'(NUM_LEDS - 1)) begin
            addr_d = led_d + LED_W'(1);
        end
        if (state_d == IDLE || state_d == LATCH) begin
            addr_d = '0;
        end

        done_d    = (state_d == LATCH) && (cyc_d == CYC_W'(TLATCH_CYC - 1));
        busy_d    = (state_d != IDLE) && !done_d;
        dout_d    = (state_d == BIT) &&
                    (cyc_d < (shift_d[23] ? CYC_W'(T1H_CYC) : CYC_W'(T0H_CYC)));
        overrun_d = bus.start && (state_q != IDLE);
    end

    assign bus.pix_addr = addr_q;
    assign bus.dout     = dout_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;

endmodule
